// File: rtl/divisible_n_sched_pkg.sv
// Shared types and the residue step rule for the divisible_n_sched scheduler.
package divisible_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  // One MSB-first step: r' = (2r+b) mod m, valid while r < m so a single subtract suffices.
  function automatic int unsigned res_step(input int unsigned r, input logic b,
                                           input int unsigned m);
    int unsigned t;
    t = 2 * r + {31'd0, b};
    return (t >= m) ? (t - m) : t;
  endfunction

endpackage

// File: rtl/divisible_residue_core.sv
// Serial residue engine: shifts one bit per enabled clock into a running residue mod MOD.
module divisible_residue_core
  import divisible_pkg::*;
#(
  parameter int MOD = 5,
  parameter int RW  = 3
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic          bit_in,
  output logic [RW-1:0] residue_nxt
);

  logic [RW-1:0] r_q, r_d;

  // The next value is exported so the caller can capture the final residue on the last bit's edge.
  always_comb begin
    r_d = r_q;
    if (clear)   r_d = '0;
    else if (en) r_d = RW'(res_step(32'(r_q), bit_in, MOD));
  end

  assign residue_nxt = r_d;

  always_ff @(posedge clk) begin
    if (!rst) r_q <= '0;
    else      r_q <= r_d;
  end

endmodule

// File: rtl/divisible_n_sched.sv
// Round-robin scheduler sharing one serial residue engine among NREQ word producers.
module divisible_n_sched
  import divisible_pkg::*;
#(
  parameter  int MOD  = 5,
  parameter  int W    = 8,
  parameter  int NREQ = 4,
  localparam int RW   = ($clog2(MOD) > 1) ? $clog2(MOD) : 1,
  localparam int IDW  = $clog2(NREQ)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_div,
  output logic [RW-1:0]     res_rem,
  output logic [IDW-1:0]    res_id,
  output logic              busy
);

  localparam int CW = $clog2(W + 1);

  if (MOD < 2)  begin : g_bad_mod  $error("MOD must be >= 2");  end
  if (W < 1)    begin : g_bad_w    $error("W must be >= 1");    end
  if (NREQ < 2) begin : g_bad_nreq $error("NREQ must be >= 2"); end

  state_e          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]  id_q, id_d, last_q, last_d, rid_q, rid_d, grant;
  logic [RW-1:0]   rem_q, rem_d, r_nxt;
  logic            div_q, div_d;
  logic            found, fire, last_bit, shift_en;

  // Rotating priority search starting just after the last granted requester.
  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        grant = idx[IDW-1:0];
      end
    end
  end

  assign fire     = (state_q == IDLE) && found;
  assign shift_en = (state_q == SHIFT);
  assign last_bit = shift_en && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      last_q  <= IDW'(NREQ - 1);
      rem_q   <= '0;
      div_q   <= 1'b0;
      rid_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      rid_q   <= rid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fire)      state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Result registers load only on the final bit, so they hold until the next DONE.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    rem_d   = rem_q;
    div_d   = div_q;
    rid_d   = rid_q;
    if (fire) begin
      shreg_d = req_data[int'(grant)*W +: W];
      cnt_d   = '0;
      id_d    = grant;
      last_d  = grant;
    end else if (shift_en) begin
      shreg_d = shreg_q << 1;
      cnt_d   = cnt_q + 1'b1;
      if (last_bit) begin
        rem_d = r_nxt;
        div_d = (r_nxt == '0);
        rid_d = id_q;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (fire) req_ready[grant] = 1'b1;
    res_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    res_rem   = rem_q;
    res_div   = div_q;
    res_id    = rid_q;
  end

  divisible_residue_core #(.MOD(MOD), .RW(RW)) u_core (
    .clk         (clk),
    .rst         (rst),
    .clear       (fire),
    .en          (shift_en),
    .bit_in      (shreg_q[W-1]),
    .residue_nxt (r_nxt)
  );

endmodule

// File: tb/tb_divisible_n_sched.sv
// Bench: MOD=5 and MOD=3 instances driven by identical stimulus, checked against word % MOD.
module tb_divisible_n_sched;
  localparam int W = 8;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_data;
  logic              res_ready;
  logic [NREQ-1:0]   rdy5, rdy3;
  logic              v5, v3, d5, d3, b5, b3;
  logic [2:0]        rem5;
  logic [1:0]        rem3, id5, id3;

  divisible_n_sched #(.MOD(5), .W(W), .NREQ(NREQ)) dut5 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy5),
    .res_valid(v5), .res_ready(res_ready), .res_div(d5), .res_rem(rem5), .res_id(id5), .busy(b5));

  divisible_n_sched #(.MOD(3), .W(W), .NREQ(NREQ)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(rdy3),
    .res_valid(v3), .res_ready(res_ready), .res_div(d3), .res_rem(rem3), .res_id(id3), .busy(b3));

  int total = 0;
  int bad = 0;

  typedef struct {
    int          idx;
    logic [7:0]  w;
    int          rem5;
    int          rem3;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rdy5"}, rdy5, 0);  chk({tag, " rdy3"}, rdy3, 0);
    chk({tag, " v5"}, v5, 0);      chk({tag, " v3"}, v3, 0);
    chk({tag, " d5"}, d5, 0);      chk({tag, " d3"}, d3, 0);
    chk({tag, " rem5"}, rem5, 0);  chk({tag, " rem3"}, rem3, 0);
    chk({tag, " id5"}, id5, 0);    chk({tag, " id3"}, id3, 0);
    chk({tag, " busy5"}, b5, 0);   chk({tag, " busy3"}, b3, 0);
  endtask

  task automatic chk_result(input string tag, input int id, input int r5, input int r3);
    chk({tag, " v5"}, v5, 1);              chk({tag, " v3"}, v3, 1);
    chk({tag, " rem5"}, rem5, r5);         chk({tag, " rem3"}, rem3, r3);
    chk({tag, " div5"}, d5, (r5 == 0));    chk({tag, " div3"}, d3, (r3 == 0));
    chk({tag, " id5"}, id5, id);           chk({tag, " id3"}, id3, id);
  endtask

  // Present a request, wait for grant, then count edges until the result appears.
  task automatic run_txn(input logic [NREQ-1:0] mask, input logic [NREQ*W-1:0] data,
                         output logic [NREQ-1:0] r5, output logic [NREQ-1:0] r3,
                         output int lat);
    int n;
    req_valid = mask;
    req_data  = data;
    #1;
    n = 0;
    while (rdy5 == '0 && n < 64) begin tick(); n++; end
    r5 = rdy5;
    r3 = rdy3;
    lat = -1;
    if (rdy5 == '0) begin
      chk("grant timeout", 0, 1);
      req_valid = '0;
    end else begin
      tick();
      req_valid = '0;
      lat = 0;
      while (!v5 && lat < 40) begin tick(); lat++; end
    end
  endtask

  task automatic release_res(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, " idle busy5"}, b5, 0);
    chk({tag, " idle v5"}, v5, 0);
    chk({tag, " idle busy3"}, b3, 0);
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    logic [NREQ-1:0] r5, r3;
    logic [NREQ*W-1:0] data;
    logic [W-1:0] w;
    int lat, got_n, last_m, g_exp, idx, dly;
    int order[5];

    vt[0] = '{0, 8'h0A, 0, 1};
    vt[1] = '{2, 8'h07, 2, 1};
    vt[2] = '{1, 8'hFF, 0, 0};
    vt[3] = '{3, 8'h00, 0, 0};
    vt[4] = '{0, 8'h80, 3, 2};
    order = '{0, 1, 2, 3, 0};

    req_valid = '0;
    req_data  = '0;
    res_ready = 1'b0;
    rst = 1'b0;
    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b1;
    tick();

    // Directed single-requester vectors; result is sampled high at edge T+W+1.
    foreach (vt[i]) begin
      data = {$urandom, $urandom};
      data[vt[i].idx*W +: W] = vt[i].w;
      run_txn(NREQ'(1) << vt[i].idx, data, r5, r3, lat);
      chk($sformatf("vec%0d grant", i), r5, NREQ'(1) << vt[i].idx);
      chk($sformatf("vec%0d latency", i), lat, W);
      chk_result($sformatf("vec%0d", i), vt[i].idx, vt[i].rem5, vt[i].rem3);
      release_res($sformatf("vec%0d", i));
    end

    // Back-pressure in DONE with every requester asking.
    data = '0;
    data[1*W +: W] = 8'h2E;
    run_txn(4'b0010, data, r5, r3, lat);
    req_valid = '1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk_result($sformatf("stall%0d", c), 1, 46 % 5, 46 % 3);
      chk($sformatf("stall%0d rdy5", c), rdy5, 0);
      chk($sformatf("stall%0d busy5", c), b5, 1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    req_valid = '0;
    chk("stall idle busy5", b5, 0);
    chk("stall idle v5", v5, 0);
    chk("stall hold rem5", rem5, 46 % 5);
    chk("stall hold id5", id5, 1);
    tick();

    // Reset asserted so that the 4th shift edge sees it.
    req_data = '0;
    req_data[0 +: W] = 8'h0A;
    req_valid = 4'b0001;
    #1;
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    tick();
    chk_reset_outputs("midreset");
    rst = 1'b1;
    tick();
    data = '0;
    data[0 +: W] = 8'h0A;
    run_txn(4'b0001, data, r5, r3, lat);
    chk("postreset latency", lat, W);
    chk_result("postreset", 0, 0, 1);
    release_res("postreset");

    // All requesters held valid: strict rotation from a fresh reset.
    do_reset();
    data = {$urandom};
    req_data = data;
    req_valid = '1;
    res_ready = 1'b1;
    got_n = 0;
    for (int c = 0; c < 200 && got_n < 5; c++) begin
      tick();
      if (v5) begin
        w = data[order[got_n]*W +: W];
        chk_result($sformatf("rr%0d", got_n), order[got_n], int'(w) % 5, int'(w) % 3);
        got_n++;
        if (got_n == 5) req_valid = '0;
      end
    end
    chk("rr results", got_n, 5);
    tick();
    res_ready = 1'b0;
    tick();

    // Random masks and words against a rotating-priority model.
    last_m = 0;
    for (int it = 0; it < 40; it++) begin
      logic [NREQ-1:0] mask;
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      data = {$urandom};
      g_exp = -1;
      for (int k = 1; k <= NREQ; k++) begin
        idx = (last_m + k) % NREQ;
        if (g_exp < 0 && mask[idx]) g_exp = idx;
      end
      run_txn(mask, data, r5, r3, lat);
      w = data[g_exp*W +: W];
      chk($sformatf("rnd%0d grant5", it), r5, NREQ'(1) << g_exp);
      chk($sformatf("rnd%0d grant3", it), r3, NREQ'(1) << g_exp);
      chk($sformatf("rnd%0d latency", it), lat, W);
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) tick();
      chk_result($sformatf("rnd%0d", it), g_exp, int'(w) % 5, int'(w) % 3);
      release_res($sformatf("rnd%0d", it));
      last_m = g_exp;
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
